// File: rtl/if_stage.sv
// Instruction fetch stage: forwards PC handshakes to a one-cycle-latency instruction memory
// and presents fetched words to decode through a two-entry (output + skid) buffer.
module if_stage #(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8:0]             pc_in,
    input  logic                   pc_valid,
    output logic                   pc_ready,
    output logic                   imem_en,
    output logic [8:0]             imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   id_valid,
    output logic [8:0]             id_pc,
    output logic [8:0]             id_pc_plus1,
    output logic [INSTR_WIDTH-1:0] id_instr
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_e;

    occ_e                   state_q;
    logic                   f_valid_q;
    logic [8:0]             f_pc_q;
    logic [8:0]             skid_pc_q;
    logic [INSTR_WIDTH-1:0] skid_instr_q;
    logic [8:0]             id_pc_q;
    logic [INSTR_WIDTH-1:0] id_instr_q;

    logic skid_valid;
    logic accept;

    assign skid_valid = (state_q == S_TWO);

    // A full skid closes the intake: the one outstanding fetch always has a slot to land in.
    assign pc_ready  = !reset && !flush && !stall && !skid_valid;
    assign accept    = pc_valid && pc_ready;
    assign imem_en   = accept;
    assign imem_addr = pc_in;

    assign id_valid    = (state_q != S_EMPTY);
    assign id_pc       = id_pc_q;
    assign id_pc_plus1 = id_pc_q + 9'd1;
    assign id_instr    = id_instr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_EMPTY;
            f_valid_q    <= 1'b0;
            f_pc_q       <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
        end else begin
            f_valid_q <= accept;
            if (accept)
                f_pc_q <= pc_in;

            if (flush) begin
                state_q   <= S_EMPTY;
                f_valid_q <= 1'b0;
            end else begin
                // imem_rdata is only valid while f_valid_q is set, so every branch consumes it now.
                case (state_q)
                    S_EMPTY: begin
                        if (f_valid_q) begin
                            id_pc_q    <= f_pc_q;
                            id_instr_q <= imem_rdata;
                            state_q    <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (stall) begin
                            if (f_valid_q) begin
                                skid_pc_q    <= f_pc_q;
                                skid_instr_q <= imem_rdata;
                                state_q      <= S_TWO;
                            end
                        end else if (f_valid_q) begin
                            id_pc_q    <= f_pc_q;
                            id_instr_q <= imem_rdata;
                        end else begin
                            state_q <= S_EMPTY;
                        end
                    end
                    S_TWO: begin
                        if (!stall) begin
                            id_pc_q    <= skid_pc_q;
                            id_instr_q <= skid_instr_q;
                            if (f_valid_q) begin
                                skid_pc_q    <= f_pc_q;
                                skid_instr_q <= imem_rdata;
                            end else begin
                                state_q <= S_ONE;
                            end
                        end
                    end
                    default: state_q <= S_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall/skid, flush, PC wrap and mid-stream reset.
module tb_if_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_en;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [8:0]  id_pc;
    logic [8:0]  id_pc_plus1;
    logic [31:0] id_instr;

    int n_vec = 0;
    int n_err = 0;

    if_stage #(.INSTR_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_pc_plus1(id_pc_plus1),
        .id_instr   (id_instr)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    // One-cycle read latency; data is not held past its valid cycle.
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= mem(imem_addr);
        else         imem_rdata <= 32'hBADB_AD00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_valid = 1'b1; pc_in = 9'd3; stall = 1'b0; flush = 1'b0;
        step(); step();
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", {23'd0, id_pc}, 32'd0);
        chk("rst_pc_plus1", {23'd0, id_pc_plus1}, 32'd1);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_pc_ready", {31'd0, pc_ready}, 32'd0);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);

        // Streaming 0..3
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc_valid = (i < 4);
            pc_in    = 9'(i);
            if (i == 0) begin
                #1;
                chk("str_imem_en", {31'd0, imem_en}, 32'd1);
                chk("str_imem_addr", {23'd0, imem_addr}, 32'd0);
                chk("str_pc_ready", {31'd0, pc_ready}, 32'd1);
            end
            step();
            if (i >= 1 && i <= 4) begin
                chk("str_id_valid", {31'd0, id_valid}, 32'd1);
                chk("str_id_pc", {23'd0, id_pc}, 32'(i - 1));
                chk("str_id_instr", id_instr, mem(9'(i - 1)));
            end else begin
                chk("str_idle_valid", {31'd0, id_valid}, 32'd0);
            end
        end

        // Stall with pc 5 in flight while pc 4 sits at the output
        pc_valid = 1'b1; pc_in = 9'd4; step();
        pc_in = 9'd5; step();
        chk("stl_id_pc4", {23'd0, id_pc}, 32'd4);
        stall = 1'b1; pc_in = 9'd6; #1;
        chk("stl_ready_stall", {31'd0, pc_ready}, 32'd0);
        step();
        chk("stl_hold_pc", {23'd0, id_pc}, 32'd4);
        chk("stl_hold_valid", {31'd0, id_valid}, 32'd1);
        step();
        chk("stl_hold_pc2", {23'd0, id_pc}, 32'd4);
        chk("stl_hold_instr", id_instr, mem(9'd4));
        stall = 1'b0; #1;
        chk("stl_ready_skid", {31'd0, pc_ready}, 32'd0);
        chk("stl_imem_en_skid", {31'd0, imem_en}, 32'd0);
        step();
        chk("stl_drain_pc", {23'd0, id_pc}, 32'd5);
        chk("stl_drain_instr", id_instr, mem(9'd5));
        chk("stl_ready_after", {31'd0, pc_ready}, 32'd1);
        step();
        pc_valid = 1'b0;
        step();
        chk("stl_next_pc", {23'd0, id_pc}, 32'd6);
        chk("stl_next_instr", id_instr, mem(9'd6));
        step();
        chk("stl_empty", {31'd0, id_valid}, 32'd0);

        // Flush while TWO: 11 is in the skid, 12 is never accepted
        pc_valid = 1'b1; pc_in = 9'd10; step();
        pc_in = 9'd11; step();
        chk("fl_id_pc10", {23'd0, id_pc}, 32'd10);
        stall = 1'b1; pc_in = 9'd12; step();
        flush = 1'b1; #1;
        chk("fl_ready", {31'd0, pc_ready}, 32'd0);
        step();
        chk("fl_cleared", {31'd0, id_valid}, 32'd0);
        flush = 1'b0; stall = 1'b0; pc_in = 9'd13; step();
        chk("fl_no_stale", {31'd0, id_valid}, 32'd0);
        pc_valid = 1'b0; step();
        chk("fl_pc13", {23'd0, id_pc}, 32'd13);
        chk("fl_instr13", id_instr, mem(9'd13));
        step();

        // Flush with a fetch in flight
        pc_valid = 1'b1; pc_in = 9'd20; step();
        pc_valid = 1'b0; flush = 1'b1; step();
        flush = 1'b0;
        chk("fli_cleared", {31'd0, id_valid}, 32'd0);
        step();
        chk("fli_discard", {31'd0, id_valid}, 32'd0);

        // PC wrap
        pc_valid = 1'b1; pc_in = 9'd511; step();
        pc_valid = 1'b0; step();
        chk("wrap_pc", {23'd0, id_pc}, 32'd511);
        chk("wrap_plus1", {23'd0, id_pc_plus1}, 32'd0);
        chk("wrap_instr", id_instr, mem(9'd511));
        step();

        // Reset mid-stream with skid full
        pc_valid = 1'b1; pc_in = 9'd30; step();
        pc_in = 9'd31; step();
        stall = 1'b1; pc_valid = 1'b0; step();
        reset = 1'b1; step();
        chk("mrst_valid", {31'd0, id_valid}, 32'd0);
        chk("mrst_pc", {23'd0, id_pc}, 32'd0);
        chk("mrst_plus1", {23'd0, id_pc_plus1}, 32'd1);
        chk("mrst_instr", id_instr, 32'd0);
        chk("mrst_ready", {31'd0, pc_ready}, 32'd0);
        reset = 1'b0; stall = 1'b0; pc_valid = 1'b1; pc_in = 9'd7; step();
        pc_valid = 1'b0; step();
        chk("mrst_pc7", {23'd0, id_pc}, 32'd7);
        chk("mrst_instr7", id_instr, mem(9'd7));
        step();
        chk("mrst_skid_gone", {31'd0, id_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
